// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment path: active-low {g,f,e,d,c,b,a} patterns,
// controller FSM states and the BCD digit decoder.
package seg_pkg;

  localparam logic [6:0] SEG_D0    = 7'h40;
  localparam logic [6:0] SEG_D1    = 7'h79;
  localparam logic [6:0] SEG_D2    = 7'h24;
  localparam logic [6:0] SEG_D3    = 7'h30;
  localparam logic [6:0] SEG_D4    = 7'h19;
  localparam logic [6:0] SEG_D5    = 7'h12;
  localparam logic [6:0] SEG_D6    = 7'h02;
  localparam logic [6:0] SEG_D7    = 7'h78;
  localparam logic [6:0] SEG_D8    = 7'h00;
  localparam logic [6:0] SEG_D9    = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_D0;
      4'd1:    s = SEG_D1;
      4'd2:    s = SEG_D2;
      4'd3:    s = SEG_D3;
      4'd4:    s = SEG_D4;
      4'd5:    s = SEG_D5;
      4'd6:    s = SEG_D6;
      4'd7:    s = SEG_D7;
      4'd8:    s = SEG_D8;
      4'd9:    s = SEG_D9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_bin2bcd.sv
// Sequential double-dabble: start loads bin, then one add-3/shift per cycle for BIN_W cycles.
// done is high during the cycle whose edge performs the final shift; bcd is valid after it.
module seg_bin2bcd
  import seg_pkg::*;
#(
  parameter int BIN_W      = 17,
  parameter int NUM_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  logic [BIN_W-1:0] sr;
  logic [CW-1:0]    cnt;
  logic [DW-1:0]    adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign done = (cnt == CW'(1));

  // Bits shifted out of the top nibble are dropped; oversized inputs are flagged by the caller.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      bcd <= '0;
      cnt <= '0;
    end else if (start) begin
      sr  <= bin;
      bcd <= '0;
      cnt <= CW'(BIN_W);
    end else if (cnt != '0) begin
      {bcd, sr} <= {adj[DW-2:0], sr, 1'b0};
      cnt       <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 7-seg scan controller: binary in over valid/ready, BCD display register loaded BIN_W+1 cycles after accept,
// bin_ready low until then (nothing queued); digits multiplexed active-low. SEG_LZ_BLANK_EN adds leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 5,
  parameter int BIN_W      = 17,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bin_valid,
  output logic                  bin_ready,
  input  logic [BIN_W-1:0]      bin_data,
  output logic                  busy,
  output logic                  ovf,
  output logic [6:0]            seg_n,
  output logic [NUM_DIGITS-1:0] dig_sel_n
);

  localparam int     DW   = 4 * NUM_DIGITS;
  localparam int     IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int     CW   = $clog2(SCAN_DIV);
  localparam longint MAXV = longint'(10) ** NUM_DIGITS - 1;

  state_t        state, state_nxt;
  logic          start, done, ovf_pend, blank;
  logic [DW-1:0] bcd, disp;
  logic [CW-1:0] div;
  logic [IW-1:0] idx;
  logic [3:0]    nib;
  logic [6:0]    seg_nxt;

  seg_bin2bcd #(.BIN_W(BIN_W), .NUM_DIGITS(NUM_DIGITS)) u_bin2bcd (
    .clk(clk), .rst(rst), .start(start), .bin(bin_data), .done(done), .bcd(bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bin_ready = 1'b0;
    start     = 1'b0;
    case (state)
      IDLE: begin
        bin_ready = 1'b1;
        if (bin_valid) begin
          start     = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV:    if (done) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // The range check is taken at accept time, so the raw value need not be kept through CONV.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp     <= '0;
      ovf      <= 1'b0;
      ovf_pend <= 1'b0;
    end else begin
      if (start) ovf_pend <= (longint'(bin_data) > MAXV);
      if (state == LOAD) begin
        disp <= bcd;
        ovf  <= ovf_pend;
      end
    end
  end

`ifdef SEG_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_mask, lz_nxt;
  logic                  lz_run;

  always_comb begin
    lz_nxt = '0;
    lz_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lz_run    = lz_run && (bcd[4*i +: 4] == 4'd0);
      lz_nxt[i] = lz_run;
    end
  end

  // Reset mask matches a cleared display so value 0 shows a single "0".
  always_ff @(posedge clk) begin
    if (rst)                lz_mask <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
    else if (state == LOAD) lz_mask <= lz_nxt;
  end
`endif

  always_comb begin
    nib   = 4'd0;
    blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib = disp[4*i +: 4];
`ifdef SEG_LZ_BLANK_EN
        blank = lz_mask[i];
`endif
      end
    end
    seg_nxt = blank ? SEG_BLANK : seg_decode(nib);
    if (ovf) seg_nxt = SEG_DASH;
  end

  // seg_n and dig_sel_n are both registered from the same idx so they never disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      div       <= '0;
      idx       <= '0;
      seg_n     <= SEG_BLANK;
      dig_sel_n <= '1;
    end else begin
      if (div == CW'(SCAN_DIV - 1)) begin
        div <= '0;
        idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        div <= div + CW'(1);
      end
      dig_sel_n <= ~(NUM_DIGITS'(1) << idx);
      seg_n     <= seg_nxt;
    end
  end

endmodule
